regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 143 ++++++++++++++
 tb/tb_regfile_sb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register scoreboard (busy bit).
// A reserve marks a destination register busy until its write-back
// arrives. pend_cnt tracks how many registers are currently busy.
// Two combinational read ports return both data and busy status.
//
// Optional feature, selected by macro REGFILE_SB_BYPASS_EN:
//   when defined, a read that hits the address being written in the same
//   cycle returns the incoming write data and the post-write busy state.
//   When undefined, reads see only the stored array and registered busy bits.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_sel,
   output logic              rsv_ready,
   input  logic [ADDR_W-1:0] rd_sel1,
   input  logic [ADDR_W-1:0] rd_sel2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   // Address 0 behaves as a constant-zero register when ZERO_REG is set.
   function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Counter step: +1 for a newly busy register, -1 for a cleared one.
   function automatic logic [ADDR_W:0] cnt_step(input logic [ADDR_W:0] cnt,
                                                input logic inc,
                                                input logic dec);
      logic [ADDR_W:0] inc_w;
      logic [ADDR_W:0] dec_w;
      inc_w = {{ADDR_W{1'b0}}, inc};
      dec_w = {{ADDR_W{1'b0}}, dec};
      return cnt + inc_w - dec_w;
   endfunction

   // Stored state (stage p1 = registered).
   logic [DATA_W-1:0] data_p1 [DEPTH];
   logic [DEPTH-1:0]  busy_p1;
   logic [ADDR_W:0]   cnt_p1;

   // Control decoded in the current cycle (stage p0).
   logic              wr_hit_p0;
   logic              rsv_ready_p0;
   logic              rsv_acc_p0;
   logic              same_addr_p0;
   logic              set_new_p0;
   logic              clr_p0;
   logic [DEPTH-1:0]  busy_nxt_p0;

   // Read port views.
   logic [ADDR_W-1:0] rd_sel_v  [2];
   logic [DATA_W-1:0] rd_data_v [2];
   logic              rd_busy_v [2];

   assign rd_sel_v[0] = rd_sel1;
   assign rd_sel_v[1] = rd_sel2;

   // Decode write/reserve acceptance and the busy-bit changes they cause.
   always_comb begin
      wr_hit_p0    = wr_en && !is_zero_addr(wr_sel);
      same_addr_p0 = (wr_sel == rsv_sel);
      // A busy target only accepts a new reserve if its write-back lands now.
      rsv_ready_p0 = !busy_p1[rsv_sel] || (wr_en && same_addr_p0)
                     || is_zero_addr(rsv_sel);
      rsv_acc_p0   = rsv_en && rsv_ready_p0 && !is_zero_addr(rsv_sel);
      // Busy register going idle -> busy is a new pending entry.
      set_new_p0   = rsv_acc_p0 && !busy_p1[rsv_sel];
      // Write-back only retires an entry if no reserve re-claims the register.
      clr_p0       = wr_hit_p0 && busy_p1[wr_sel]
                     && !(rsv_acc_p0 && same_addr_p0);
      busy_nxt_p0  = busy_p1;
      if (wr_hit_p0) begin
         busy_nxt_p0[wr_sel] = 1'b0;
      end
      if (rsv_acc_p0) begin
         busy_nxt_p0[rsv_sel] = 1'b1;
      end
   end

   // ---- p0 -> p1 boundary ----

   // Data array: one-cycle write latency; reset wipes all contents.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_p1[i] <= '0;
         end
      end else if (wr_hit_p0) begin
         data_p1[wr_sel] <= wr_data;
      end
   end

   // Scoreboard busy bits and pending count, updated in lock-step.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_p1 <= '0;
         cnt_p1  <= '0;
      end else begin
         busy_p1 <= busy_nxt_p0;
         cnt_p1  <= cnt_step(cnt_p1, set_new_p0, clr_p0);
      end
   end

   // Combinational read ports with zero-register masking and optional bypass.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data_v[p] = data_p1[rd_sel_v[p]];
         rd_busy_v[p] = busy_p1[rd_sel_v[p]];
`ifdef REGFILE_SB_BYPASS_EN
         if (wr_hit_p0 && (rd_sel_v[p] == wr_sel)) begin
            rd_data_v[p] = wr_data;
            rd_busy_v[p] = rsv_acc_p0 && same_addr_p0;
         end
`endif
         if (is_zero_addr(rd_sel_v[p])) begin
            rd_data_v[p] = '0;
            rd_busy_v[p] = 1'b0;
         end
      end
   end

   assign rd_data1  = rd_data_v[0];
   assign rd_data2  = rd_data_v[1];
   assign rd_busy1  = rd_busy_v[0];
   assign rd_busy2  = rd_busy_v[1];
   assign rsv_ready = rsv_ready_p0;
   assign pend_cnt  = cnt_p1;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios followed by random traffic, checked
// against a behavioural model (plain arrays, busy count by population).
module tb_regfile_sb;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 1;
   localparam int DEPTH    = 2**ADDR_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_sel;
   logic              rsv_ready;
   logic [ADDR_W-1:0] rd_sel1;
   logic [ADDR_W-1:0] rd_sel2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic [ADDR_W:0]   pend_cnt;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] mmem  [DEPTH];
   bit                mbusy [DEPTH];

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_sel  (rsv_sel),
      .rsv_ready(rsv_ready),
      .rd_sel1  (rd_sel1),
      .rd_sel2  (rd_sel2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .rd_busy1 (rd_busy1),
      .rd_busy2 (rd_busy2),
      .pend_cnt (pend_cnt)
   );

   always #5 clock = ~clock;

   function automatic bit zr(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == 0);
   endfunction

   function automatic int mcount();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += mbusy[i];
      return n;
   endfunction

   function automatic bit exp_ready();
      return zr(rsv_sel) || !mbusy[rsv_sel] || (wr_en && wr_sel == rsv_sel);
   endfunction

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
      if (zr(a)) return '0;
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && !zr(wr_sel) && a == wr_sel) return wr_data;
`endif
      return mmem[a];
   endfunction

   function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
      if (zr(a)) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && !zr(wr_sel) && a == wr_sel)
         return rsv_en && exp_ready() && !zr(rsv_sel) && rsv_sel == a;
`endif
      return mbusy[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mmem[i]  = '0;
         mbusy[i] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_sel = '0;
   endtask

   // Check all outputs against the model, clock once, advance the model.
   task automatic step();
      bit acc;
      #1;
      chk("rd_data1", 64'(rd_data1), 64'(exp_data(rd_sel1)));
      chk("rd_data2", 64'(rd_data2), 64'(exp_data(rd_sel2)));
      chk("rd_busy1", 64'(rd_busy1), 64'(exp_busy(rd_sel1)));
      chk("rd_busy2", 64'(rd_busy2), 64'(exp_busy(rd_sel2)));
      chk("rsv_ready", 64'(rsv_ready), 64'(exp_ready()));
      chk("pend_cnt", 64'(pend_cnt), 64'(mcount()));
      acc = rsv_en && exp_ready() && !zr(rsv_sel);
      @(posedge clock);
      if (reset) begin
         model_clear();
      end else begin
         if (wr_en && !zr(wr_sel)) begin
            mmem[wr_sel]  = wr_data;
            mbusy[wr_sel] = 1'b0;
         end
         if (acc) mbusy[rsv_sel] = 1'b1;
      end
      #1;
   endtask

   task automatic do_write(input int a, input logic [DATA_W-1:0] d);
      idle(); wr_en = 1'b1; wr_sel = ADDR_W'(a); wr_data = d;
   endtask

   task automatic do_rsv(input int a);
      idle(); rsv_en = 1'b1; rsv_sel = ADDR_W'(a);
   endtask

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
      return ADDR_W'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      rd_sel1 = '0; rd_sel2 = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      model_clear();
      step();

      // Post-reset state
      idle(); rd_sel1 = 5'd4; rd_sel2 = 5'd31; rsv_sel = 5'd6;
      #1;
      chk("rst_data", 64'(rd_data1), 64'h0);
      chk("rst_busy", 64'(rd_busy2), 64'h0);
      chk("rst_ready", 64'(rsv_ready), 64'h1);
      chk("rst_cnt", 64'(pend_cnt), 64'h0);
      step();

      // Write r5, read next cycle
      do_write(5, 32'hDEADBEEF); rd_sel1 = 5'd5;
      step();
      idle(); rd_sel1 = 5'd5;
      #1;
      chk("r5_data", 64'(rd_data1), 64'hDEADBEEF);
      chk("r5_busy", 64'(rd_busy1), 64'h0);
      step();

      // Zero register ignores writes and reserves
      do_write(0, 32'h1234); rd_sel1 = 5'd0;
      step();
      do_rsv(0); rd_sel1 = 5'd0;
      #1;
      chk("r0_data", 64'(rd_data1), 64'h0);
      chk("r0_ready", 64'(rsv_ready), 64'h1);
      step();
      idle(); rd_sel1 = 5'd0;
      #1;
      chk("r0_busy", 64'(rd_busy1), 64'h0);
      chk("r0_cnt", 64'(pend_cnt), 64'h0);
      step();

      // WAW hazard on r3
      do_rsv(3);
      step();
      do_rsv(3);
      #1;
      chk("waw_ready", 64'(rsv_ready), 64'h0);
      step();
      idle();
      #1;
      chk("waw_cnt", 64'(pend_cnt), 64'h1);
      do_write(3, 32'h33); rsv_en = 1'b1; rsv_sel = 5'd3;
      #1;
      chk("wr_rsv_ready", 64'(rsv_ready), 64'h1);
      step();
      idle(); rd_sel1 = 5'd3;
      #1;
      chk("wr_rsv_busy", 64'(rd_busy1), 64'h1);
      chk("wr_rsv_cnt", 64'(pend_cnt), 64'h1);
      do_write(3, 32'h34);
      step();

      // Reserve r1, r2, r7 then write r2
      do_rsv(1); step(); #1; chk("cnt1", 64'(pend_cnt), 64'd1);
      do_rsv(2); step(); #1; chk("cnt2", 64'(pend_cnt), 64'd2);
      do_rsv(7); step(); #1; chk("cnt3", 64'(pend_cnt), 64'd3);
      do_write(2, 32'h22); step();
      idle(); rd_sel1 = 5'd2; rd_sel2 = 5'd7;
      #1;
      chk("cnt_after_wr", 64'(pend_cnt), 64'd2);
      chk("r2_busy", 64'(rd_busy1), 64'h0);
      chk("r7_busy", 64'(rd_busy2), 64'h1);
      step();

      // Same-cycle read of a register being written
      do_write(9, 32'h11111111); step();
      do_write(9, 32'hA5A5A5A5); rd_sel1 = 5'd9;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("bypass_r9", 64'(rd_data1), 64'hA5A5A5A5);
`else
      chk("nobypass_r9", 64'(rd_data1), 64'h11111111);
`endif
      step();
      idle(); rd_sel1 = 5'd9;
      #1;
      chk("r9_next", 64'(rd_data1), 64'hA5A5A5A5);
      step();

      // Reset with four busy registers and a write in flight
      do_rsv(10); step();
      do_rsv(11); step();
      idle();
      #1;
      chk("busy4_cnt", 64'(pend_cnt), 64'd4);
      do_write(12, 32'hFFFF); reset = 1'b1;
      step();
      idle(); rd_sel1 = 5'd12; rd_sel2 = 5'd9;
      #1;
      chk("rst4_cnt", 64'(pend_cnt), 64'd0);
      chk("rst4_r12", 64'(rd_data1), 64'h0);
      chk("rst4_r9", 64'(rd_data2), 64'h0);
      step();
      idle(); rd_sel1 = 5'd7;
      #1;
      chk("rst4_busy7", 64'(rd_busy1), 64'h0);
      step();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         reset   = ($urandom_range(0, 79) == 0);
         wr_en   = $urandom_range(0, 1);
         wr_sel  = rnd_addr();
         wr_data = $urandom;
         rsv_en  = $urandom_range(0, 1);
         rsv_sel = ($urandom_range(0, 3) == 0) ? wr_sel : rnd_addr();
         rd_sel1 = ($urandom_range(0, 2) == 0) ? wr_sel : rnd_addr();
         rd_sel2 = ($urandom_range(0, 2) == 0) ? rsv_sel : rnd_addr();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
